// File: rtl/alu_sched_pkg.sv
// Shared types for the round-robin ALU scheduler.
package alu_sched_pkg;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      XOR = 3'b011
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx,
   output logic            any_grant
);

   logic [PW-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = PW'((32'(ptr) + k) % NREQ);
         if (!any_grant && req[cand]) begin
            any_grant   = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external ALU among NREQ requesters: arbitrate, execute from
// registered operands, then hold the result until the winner accepts it.
module alu_scheduler
   import alu_sched_pkg::*;
#(
   parameter int unsigned N    = 8,
   parameter int unsigned NREQ = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   input  logic [NREQ*3-1:0] req_op,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [N-1:0]      rsp_result,
   output logic              busy,
   output logic [N-1:0]      alu_a,
   output logic [N-1:0]      alu_b,
   output logic [2:0]        alu_opcode,
   input  logic [N-1:0]      alu_result
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_state_e    state_q;
   logic [PW-1:0]   rr_ptr_q;
   logic [PW-1:0]   id_q;
   logic [N-1:0]    a_q, b_q, res_q;
   logic [2:0]      op_q;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic            any_grant;
   logic [N-1:0]    win_a, win_b;
   logic [2:0]      win_op;
   logic [PW-1:0]   rr_ptr_d;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Operand mux for the current winner.
   always_comb begin
      win_a  = '0;
      win_b  = '0;
      win_op = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_idx == PW'(i)) begin
            win_a  = req_a[i*N +: N];
            win_b  = req_b[i*N +: N];
            win_op = req_op[i*3 +: 3];
         end
      end
   end

   assign rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         res_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_grant) begin
                  a_q      <= win_a;
                  b_q      <= win_b;
                  op_q     <= win_op;
                  id_q     <= grant_idx;
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               res_q   <= alu_result;
               state_q <= RESP;
            end
            RESP: begin
               if (rsp_ready[id_q]) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Handshake signals decoded from registered state only.
   always_comb begin
      rsp_valid = '0;
      if (state_q == RESP) rsp_valid[id_q] = 1'b1;
   end

   assign req_ready  = (state_q == IDLE) ? grant : '0;
   assign rsp_result = res_q;
   assign busy       = (state_q != IDLE);
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_opcode = op_q;

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Round-robin scheduler that shares one `Nalu_structural` instance between `NREQ` independent requesters. Each requester submits an operand pair plus 3-bit opcode over a valid/ready handshake. The scheduler arbitrates, drives the ALU from registered operands and returns the result to the winning requester over a per-requester valid/ready response channel. It sits between client blocks and the ALU instance and is the only driver of the ALU inputs.

## Interface
- `N`, 8: operand and result width; must match the shared ALU's `N`
- `NREQ`, 4: number of requesters; ≥2; pointer width is `$clog2(NREQ)`

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  request valid, one bit per requester
- `req_ready`  out  NREQ  request accepted; at most one bit high
- `req_a`  in  NREQ*N  operand a; requester i at bits [i*N +: N]
- `req_b`  in  NREQ*N  operand b; same packing
- `req_op`  in  NREQ*3  opcode; requester i at bits [i*3 +: 3]
- `rsp_valid`  out  NREQ  response valid; at most one bit high
- `rsp_ready`  in  NREQ  response accepted by requester
- `rsp_result`  out  N  result for the requester flagged by `rsp_valid`
- `busy`  out  1  high whenever state ≠ IDLE
- `alu_a`, `alu_b`  out  N  to ALU `a`, `b`
- `alu_opcode`  out  3  to ALU `opcode`
- `alu_result`  in  N  from ALU `result` (combinational)

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Round-robin pick: the lowest index ≥ `rr_ptr` (wrapping) with `req_valid` high.
  - `req_ready` is asserted combinationally for the winner only.
  - Accept = winner's valid & ready. On accept:
    - capture a, b, op and the winner index into `a_q`, `b_q`, `op_q`, `id_q`;
    - `rr_ptr` ← (winner+1) mod NREQ;
    - go to EXEC.
  - If no request is valid, stay in IDLE; `rr_ptr` is unchanged.
- **EXEC**
  - `alu_*` are driven from the `_q` registers.
  - At the clock edge, `res_q` ← `alu_result`; go to RESP.
- **RESP**
  - `rsp_valid[id_q]` = 1; `rsp_result` = `res_q`.
  - On `rsp_ready[id_q]`, go to IDLE. `rsp_ready` bits of other requesters are ignored.
  - Otherwise hold, with `rsp_result` stable.
- `req_ready` is 0 for every requester in EXEC and RESP.
- Opcodes are passed through unmodified:
  - 000 add and 001 sub wrap modulo 2^N, with no carry or borrow out;
  - 010 and; 011 xor;
  - 1xx produces all-ones from the ALU and is returned as-is, not flagged as an error.
- `alu_*` always reflect the `_q` registers, so the ALU inputs are glitch-free between operations.

## Timing
- Reset values:
  - state = IDLE; `rr_ptr` = 0;
  - `a_q`, `b_q`, `op_q`, `id_q`, `res_q` = 0;
  - hence `alu_a` = `alu_b` = 0, `alu_opcode` = 000, `rsp_valid` = 0, `rsp_result` = 0, `busy` = 0.
- `req_ready` may be high during reset if `req_valid` is high, but no capture occurs while `rst_n` is low.
- Latency: accept in cycle T → `rsp_valid` high in T+2.
- Minimum issue interval: 3 cycles per operation (accept, EXEC, RESP with `rsp_ready` already high). The next accept is in the cycle after the response handshake, never the same cycle.
- A requester must hold `req_a`/`req_b`/`req_op` stable while its `req_valid` is high. It may drop `req_valid` before acceptance; that is legal and loses nothing.
- A requester that is back-pressuring the response (`rsp_ready` low) stalls all requesters indefinitely. This is by design: there is no response buffering.
- Reset mid-operation: the in-flight op is discarded and no response is produced. Outputs return to their reset values immediately.
- Simultaneous requests: exactly one is accepted per IDLE visit. A requester that stays valid is granted within NREQ operations (starvation-free).

## Structure
- Package `alu_sched_pkg`:
  - `alu_op_e` enum: ADD = 3'b000, SUB = 3'b001, AND = 3'b010, XOR = 3'b011;
  - `sched_state_e` enum: IDLE, EXEC, RESP.
- Sub-module `rr_arbiter #(NREQ)`:
  - inputs: `req`, `ptr`;
  - outputs: one-hot `grant`, encoded `grant_idx`, `any_grant`;
  - purely combinational.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- **Single op (N=8):** only requester 0 sends a=8'h7F, b=8'h01, op=000 → `rsp_valid`=4'b0001 two cycles after accept, `rsp_result`=8'h80.
- **Round-robin:** all 4 requesters valid continuously with `rsp_ready` all 1 → grant order 0,1,2,3,0; each accept 3 cycles apart.
- **Back-pressure:** requester 2 sends a=8'h05, b=8'h07, op=001; `rsp_ready` held 0 for 5 cycles:
  - `rsp_result`=8'hFE stable;
  - `req_ready`=0 for all throughout;
  - completes on the cycle `rsp_ready[2]` rises.
- **Illegal opcode:** op=3'b110 → `rsp_result`=8'hFF. Also op=010 with a=8'hF0, b=8'h3C → 8'h30; op=011 → 8'hCC.
- **Reset mid-op:** `rst_n` low during EXEC → `rsp_valid`=0, `busy`=0, `alu_a`=0. The first request after release is granted starting from requester 0.
- **Wrong-requester ready:** in RESP for requester 1, `rsp_ready`=4'b0100 → stays in RESP; completes only when bit 1 is high.
